// File: rtl/bp_cce_mode_switch_ctrl.sv
// rtl/bp_cce_mode_switch_ctrl.sv - sequences CCE switches between uncached and cached message units
module bp_cce_mode_switch_ctrl #(
    parameter int max_outstanding_p = 8,
    localparam int cw = ((max_outstanding_p + 1) <= 1) ? 1 : $clog2(max_outstanding_p + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          mode_req_i,
    input  logic          lce_req_v_i,
    output logic          lce_req_v_o,
    input  logic          unit_busy_i,
    input  logic          mem_cmd_v_i,
    output logic          mem_cmd_ready_o,
    output logic          mem_cmd_v_o,
    input  logic          mem_cmd_ready_i,
    input  logic          mem_resp_v_i,
    input  logic          mem_resp_yumi_i,
    output logic          sel_uncached_o,
    output logic          switch_busy_o,
    output logic [cw-1:0] outstanding_o,
    output logic          underflow_err_o
);

    typedef enum logic [1:0] {
        e_run    = 2'd0,
        e_drain  = 2'd1,
        e_switch = 2'd2
    } state_e;

    state_e        state_r;
    logic          cur_mode_r;
    logic [cw-1:0] count_r;
    logic          err_r;
    logic          switch_busy_r;

    logic full;
    logic inc;
    logic dec;
    logic mode_match;

    assign full       = (count_r == cw'(max_outstanding_p));
    assign mode_match = (mode_req_i == cur_mode_r);

    // Full gating applies to both handshake directions so the counter can never overflow
    assign mem_cmd_v_o     = mem_cmd_v_i & ~full;
    assign mem_cmd_ready_o = mem_cmd_ready_i & ~full;

    assign inc = mem_cmd_v_o & mem_cmd_ready_i;
    assign dec = mem_resp_v_i & mem_resp_yumi_i;

    // A mismatch blocks hand-over in the very cycle it is first seen
    assign lce_req_v_o = (state_r == e_run) & lce_req_v_i & mode_match;

    assign sel_uncached_o  = cur_mode_r;
    assign switch_busy_o   = switch_busy_r;
    assign outstanding_o   = count_r;
    assign underflow_err_o = err_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= '0;
            err_r   <= 1'b0;
        end else begin
            if (inc & ~dec) begin
                count_r <= count_r + cw'(1);
            end else if (dec & ~inc) begin
                if (count_r == '0) begin
                    err_r <= 1'b1;
                end else begin
                    count_r <= count_r - cw'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r       <= e_run;
            cur_mode_r    <= 1'b1;
            switch_busy_r <= 1'b0;
        end else begin
            case (state_r)
                e_run: begin
                    if (!mode_match) begin
                        state_r       <= e_drain;
                        switch_busy_r <= 1'b1;
                    end
                end
                e_drain: begin
                    // Withdrawal wins over completion of the drain
                    if (mode_match) begin
                        state_r       <= e_run;
                        switch_busy_r <= 1'b0;
                    end else if ((count_r == '0) & ~unit_busy_i & ~inc) begin
                        state_r       <= e_switch;
                        switch_busy_r <= 1'b1;
                    end
                end
                e_switch: begin
                    cur_mode_r    <= ~cur_mode_r;
                    state_r       <= e_run;
                    switch_busy_r <= 1'b0;
                end
                default: begin
                    state_r       <= e_run;
                    switch_busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bp_cce_mode_switch_ctrl.sv
// tb/tb_bp_cce_mode_switch_ctrl.sv - directed vector bench for bp_cce_mode_switch_ctrl
module tb_bp_cce_mode_switch_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       mode_req_i = 1'b1;
    logic       lce_req_v_i = 1'b1;
    logic       lce_req_v_o;
    logic       unit_busy_i = 1'b0;
    logic       mem_cmd_v_i = 1'b0;
    logic       mem_cmd_ready_o;
    logic       mem_cmd_v_o;
    logic       mem_cmd_ready_i = 1'b0;
    logic       mem_resp_v_i = 1'b0;
    logic       mem_resp_yumi_i = 1'b0;
    logic       sel_uncached_o;
    logic       switch_busy_o;
    logic [3:0] outstanding_o;
    logic       underflow_err_o;

    bp_cce_mode_switch_ctrl #(.max_outstanding_p(8)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .mode_req_i      (mode_req_i),
        .lce_req_v_i     (lce_req_v_i),
        .lce_req_v_o     (lce_req_v_o),
        .unit_busy_i     (unit_busy_i),
        .mem_cmd_v_i     (mem_cmd_v_i),
        .mem_cmd_ready_o (mem_cmd_ready_o),
        .mem_cmd_v_o     (mem_cmd_v_o),
        .mem_cmd_ready_i (mem_cmd_ready_i),
        .mem_resp_v_i    (mem_resp_v_i),
        .mem_resp_yumi_i (mem_resp_yumi_i),
        .sel_uncached_o  (sel_uncached_o),
        .switch_busy_o   (switch_busy_o),
        .outstanding_o   (outstanding_o),
        .underflow_err_o (underflow_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       mr, lv, ub, cv, cr, rv, ry;
        logic       lo, cvo, cro, sel, bsy;
        logic [3:0] cnt;
        logic       err;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic v(input logic mr, lv, ub, cv, cr, rv, ry,
                     input logic lo, cvo, cro, sel, bsy, input int cnt, input logic err);
        vec_t r;
        r.mr = mr; r.lv = lv; r.ub = ub; r.cv = cv; r.cr = cr; r.rv = rv; r.ry = ry;
        r.lo = lo; r.cvo = cvo; r.cro = cro; r.sel = sel; r.bsy = bsy;
        r.cnt = 4'(cnt); r.err = err;
        tbl.push_back(r);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[%0d] got %0d expected %0d", name, idx, act, exp);
    endtask

    task automatic check_all(input int idx, input vec_t r);
        check("lce_req_v_o", idx, int'(lce_req_v_o), int'(r.lo));
        check("mem_cmd_v_o", idx, int'(mem_cmd_v_o), int'(r.cvo));
        check("mem_cmd_ready_o", idx, int'(mem_cmd_ready_o), int'(r.cro));
        check("sel_uncached_o", idx, int'(sel_uncached_o), int'(r.sel));
        check("switch_busy_o", idx, int'(switch_busy_o), int'(r.bsy));
        check("outstanding_o", idx, int'(outstanding_o), int'(r.cnt));
        check("underflow_err_o", idx, int'(underflow_err_o), int'(r.err));
    endtask

    task automatic drive(input vec_t r);
        mode_req_i = r.mr; lce_req_v_i = r.lv; unit_busy_i = r.ub;
        mem_cmd_v_i = r.cv; mem_cmd_ready_i = r.cr;
        mem_resp_v_i = r.rv; mem_resp_yumi_i = r.ry;
    endtask

    task automatic idle(input logic mr, input logic lv);
        mode_req_i = mr; lce_req_v_i = lv; unit_busy_i = 1'b0;
        mem_cmd_v_i = 1'b0; mem_cmd_ready_i = 1'b0;
        mem_resp_v_i = 1'b0; mem_resp_yumi_i = 1'b0;
    endtask

    initial begin
        vec_t rst_exp;
        int   waited;

        // idle switch uncached -> cached
        v(1,1,0,0,0,0,0, 1,0,0,1,0, 0,0);
        v(0,1,0,0,0,0,0, 0,0,0,1,0, 0,0);
        v(0,1,0,0,0,0,0, 0,0,0,1,1, 0,0);
        v(0,1,0,0,0,0,0, 0,0,0,1,1, 0,0);
        v(0,1,0,0,0,0,0, 1,0,0,0,0, 0,0);
        // three commands outstanding, then switch back; drain waits on yumis and unit_busy
        v(0,0,0,1,1,0,0, 0,1,1,0,0, 0,0);
        v(0,0,0,1,1,0,0, 0,1,1,0,0, 1,0);
        v(0,0,0,1,1,0,0, 0,1,1,0,0, 2,0);
        v(1,1,0,0,0,0,0, 0,0,0,0,0, 3,0);
        v(1,0,0,0,0,1,1, 0,0,0,0,1, 3,0);
        v(1,0,0,0,0,1,1, 0,0,0,0,1, 2,0);
        v(1,0,0,0,0,1,1, 0,0,0,0,1, 1,0);
        v(1,0,1,0,0,0,0, 0,0,0,0,1, 0,0);
        v(1,0,0,0,0,0,0, 0,0,0,0,1, 0,0);
        v(1,0,0,0,0,0,0, 0,0,0,0,1, 0,0);
        v(1,1,0,0,0,0,0, 1,0,0,1,0, 0,0);
        // fill to max, then full-gated cmd with response: 8 -> 7 -> 7
        for (int i = 0; i < 8; i++) v(1,0,0,1,1,0,0, 0,1,1,1,0, i,0);
        v(1,0,0,1,1,0,0, 0,0,0,1,0, 8,0);
        v(1,0,0,1,1,1,1, 0,0,0,1,0, 8,0);
        v(1,0,0,1,1,1,1, 0,1,1,1,0, 7,0);
        v(1,0,0,0,0,0,0, 0,0,0,1,0, 7,0);
        for (int i = 7; i >= 1; i--) v(1,0,0,0,0,1,1, 0,0,0,1,0, i,0);
        // underflow: sticky, count held at 0
        v(1,0,0,0,0,1,1, 0,0,0,1,0, 0,0);
        v(1,0,0,0,0,0,0, 0,0,0,1,0, 0,1);
        v(1,0,0,1,1,0,0, 0,1,1,1,0, 0,1);
        v(1,0,0,0,0,1,1, 0,0,0,1,0, 1,1);
        v(1,1,0,0,0,0,0, 1,0,0,1,0, 0,1);

        // reset state with mode_req=1, lce_req_v=1
        #1 reset_i = 1'b1;
        @(posedge clk_i); #1;
        rst_exp = '{mr:1, lv:1, ub:0, cv:0, cr:0, rv:0, ry:0,
                    lo:1, cvo:0, cro:0, sel:1, bsy:0, cnt:4'd0, err:0};
        check_all(-1, rst_exp);
        @(posedge clk_i); #1;
        reset_i = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk_i);
            check_all(i, tbl[i]);
            @(posedge clk_i); #1;
        end

        // asynchronous reset clears the sticky error between edges
        idle(1'b1, 1'b0);
        #1 reset_i = 1'b1;
        #1 reset_i = 1'b0;
        #1;
        check("async_rst_err", 0, int'(underflow_err_o), 0);
        check("async_rst_cnt", 0, int'(outstanding_o), 0);
        @(posedge clk_i); #1;

        // request withdrawn during DRAIN: back to RUN, select unchanged
        idle(1'b0, 1'b1);
        @(negedge clk_i);
        check("wd_gate", 0, int'(lce_req_v_o), 0);
        @(posedge clk_i); #1;
        check("wd_drain", 0, int'(switch_busy_o), 1);
        mode_req_i = 1'b1;
        @(posedge clk_i); #1;
        check("wd_run", 0, int'(switch_busy_o), 0);
        check("wd_sel", 0, int'(sel_uncached_o), 1);
        check("wd_lce", 0, int'(lce_req_v_o), 1);

        // switch to cached with a bounded wait
        mode_req_i = 1'b0;
        waited = 0;
        while (sel_uncached_o !== 1'b0 && waited < 10) begin
            @(posedge clk_i); #1;
            waited++;
        end
        check("sw_sel", 0, int'(sel_uncached_o), 0);
        check("sw_latency", 0, waited, 3);
        check("sw_busy", 0, int'(switch_busy_o), 0);

        // one command outstanding keeps DRAIN; reset mid-DRAIN forces RUN/uncached/0
        mem_cmd_v_i = 1'b1; mem_cmd_ready_i = 1'b1;
        @(posedge clk_i); #1;
        mem_cmd_v_i = 1'b0; mem_cmd_ready_i = 1'b0;
        mode_req_i = 1'b1;
        check("dr_cnt", 0, int'(outstanding_o), 1);
        @(posedge clk_i); #1;
        check("dr_busy", 0, int'(switch_busy_o), 1);
        @(posedge clk_i); #1;
        check("dr_hold", 0, int'(switch_busy_o), 1);
        check("dr_sel", 0, int'(sel_uncached_o), 0);
        #2 reset_i = 1'b1;
        #1;
        check("mid_rst_busy", 0, int'(switch_busy_o), 0);
        check("mid_rst_sel", 0, int'(sel_uncached_o), 1);
        check("mid_rst_cnt", 0, int'(outstanding_o), 0);
        check("mid_rst_lce", 0, int'(lce_req_v_o), 1);
        @(posedge clk_i); #1;
        reset_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
